// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Fetch PC register with stall/redirect handling and a direct-mapped branch
// target buffer (BTB). Each BTB entry holds a valid bit, a tag, a word-aligned
// target and a 2-bit saturating direction counter.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous active-high reset
//   stall        hold PC (IF/ID back-pressure)
//   redirect     execute-stage correction, overrides stall
//   redirect_pc  corrected next PC (bits [1:0] forced to 0)
//   upd_valid    resolved branch/jump updates the BTB this cycle
//   upd_pc       PC of the resolved instruction
//   upd_taken    resolved direction
//   upd_target   resolved target address
//   btb_flush    invalidate every BTB entry (wins over upd_valid)
//   PC           registered fetch PC
//   pred_taken   BTB predicts the current PC as taken (combinational)
//   pc_plus4     PC + 4, wrapping modulo 2^WIDTH (combinational)

module pc_fetch_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      BTB_ENTRIES  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             btb_flush,
    output logic [WIDTH-1:0] PC,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pc_plus4
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = WIDTH - IDX - 2;

    logic [WIDTH-1:0]       r_pc;
    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]        r_tag [BTB_ENTRIES];
    logic [WIDTH-3:0]       r_tgt [BTB_ENTRIES];
    logic [1:0]             r_ctr [BTB_ENTRIES];

    logic [IDX-1:0]   w_lk_idx;
    logic [TAGW-1:0]  w_lk_tag;
    logic             w_lk_hit;
    logic [WIDTH-1:0] w_pred_tgt;
    logic [IDX-1:0]   w_up_idx;
    logic [TAGW-1:0]  w_up_tag;
    logic             w_up_hit;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_unused;

    // Address bits [1:0] never participate in indexing, tagging or targets.
    assign w_unused = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    // Lookup on the current PC; reads pre-update contents, no bypass.
    assign w_lk_idx   = r_pc[IDX+1:2];
    assign w_lk_tag   = r_pc[WIDTH-1:IDX+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken = w_lk_hit && r_ctr[w_lk_idx][1];
    assign w_pred_tgt = {r_tgt[w_lk_idx], 2'b00};

    assign PC       = r_pc;
    assign pc_plus4 = r_pc + WIDTH'(4);

    always_comb begin
        w_next_pc = pc_plus4;
        if (redirect) begin
            w_next_pc = {redirect_pc[WIDTH-1:2], 2'b00};
        end else if (stall) begin
            w_next_pc = r_pc;
        end else if (pred_taken) begin
            w_next_pc = w_pred_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // Update-side lookup on the resolved instruction's PC.
    assign w_up_idx = upd_pc[IDX+1:2];
    assign w_up_tag = upd_pc[WIDTH-1:IDX+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (btb_flush) begin
            r_valid <= '0;
        end else if (upd_valid && upd_taken && !w_up_hit) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Payload fields are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && !btb_flush && upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    r_ctr[w_up_idx] <= (r_ctr[w_up_idx] == 2'b11) ? 2'b11 : r_ctr[w_up_idx] + 2'd1;
                    r_tgt[w_up_idx] <= upd_target[WIDTH-1:2];
                end else begin
                    r_ctr[w_up_idx] <= (r_ctr[w_up_idx] == 2'b00) ? 2'b00 : r_ctr[w_up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // New entries start weakly taken.
                r_tag[w_up_idx] <= w_up_tag;
                r_tgt[w_up_idx] <= upd_target[WIDTH-1:2];
                r_ctr[w_up_idx] <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver pushes the expected outputs of
// each cycle from a behavioural BTB model; the monitor pops and compares.

module tb_pc_fetch_unit;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        btb_flush = 1'b0;
    logic [31:0] PC;
    logic        pred_taken;
    logic [31:0] pc_plus4;

    pc_fetch_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .BTB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .btb_flush(btb_flush),
        .PC(PC), .pred_taken(pred_taken), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] p4;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 1'b0;

    // Reference model: the BTB as plain arrays keyed by word address.
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] a);
        return a >> 6;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Drive one cycle of stimulus, predict that cycle's outputs, advance model.
    task automatic cycle(input bit i_rst, input bit i_stall, input bit i_redir,
                         input logic [31:0] i_rpc, input bit i_uv,
                         input logic [31:0] i_upc, input bit i_ut,
                         input logic [31:0] i_utgt, input bit i_flush);
        exp_t e;
        int   i;
        bit   hit;
        bit   pred;
        @(posedge clk);
        #1;
        rst = i_rst; stall = i_stall; redirect = i_redir; redirect_pc = i_rpc;
        upd_valid = i_uv; upd_pc = i_upc; upd_taken = i_ut;
        upd_target = i_utgt; btb_flush = i_flush;
        if (i_rst) begin
            m_pc = 32'h0;
            for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
        end
        i    = idx_of(m_pc);
        pred = m_valid[i] && (m_tag[i] == tag_of(m_pc)) && (m_ctr[i] >= 2);
        e.pc = m_pc; e.pred = pred; e.p4 = m_pc + 32'd4;
        q.push_back(e);
        if (!i_rst) begin
            if (i_redir)     m_pc = i_rpc & ~32'h3;
            else if (i_stall) m_pc = m_pc;
            else if (pred)   m_pc = m_tgt[i];
            else             m_pc = m_pc + 32'd4;
            if (i_flush) begin
                for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
            end else if (i_uv) begin
                i   = idx_of(i_upc);
                hit = m_valid[i] && (m_tag[i] == tag_of(i_upc));
                if (hit && i_ut) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = i_utgt & ~32'h3;
                end else if (hit) begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end else if (i_ut) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(i_upc);
                    m_tgt[i]   = i_utgt & ~32'h3;
                    m_ctr[i]   = 2;
                end
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redir(input logic [31:0] a);
        cycle(0, 0, 1, a, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] a, input bit t, input logic [31:0] tgt);
        cycle(0, 1, 0, 0, 1, a, t, tgt, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        base = ($urandom_range(0, 3) == 0) ? 32'h0000_1000 : 32'h0;
        return base + ($urandom_range(0, 47) << 2) + 32'($urandom_range(0, 3));
    endfunction

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pc", PC, e.pc);
                check("pred_taken", {31'b0, pred_taken}, {31'b0, e.pred});
                check("pc_plus4", pc_plus4, e.p4);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 0;
        end
        m_pc = 32'h0;

        // Reset and sequential fetch.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle(); idle();
        // Stall at 0x8 -> wait, stall, stall, release.
        redir(32'h8);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle();
        // Redirect overrides stall, low bits dropped.
        cycle(0, 1, 1, 32'h103, 0, 0, 0, 0, 0);
        idle();
        // Allocate while PC is 0x10: same-cycle lookup still misses.
        redir(32'h10);
        cycle(0, 0, 0, 0, 1, 32'h10, 1, 32'h40, 0);
        redir(32'h10); idle(); idle();
        // Counter hysteresis.
        upd(32'h10, 1, 32'h40);
        upd(32'h10, 0, 0);
        redir(32'h10); idle(); idle();
        upd(32'h10, 0, 0);
        redir(32'h10); idle(); idle();
        upd(32'h10, 0, 0); upd(32'h10, 0, 0);
        upd(32'h10, 1, 32'h40);
        redir(32'h10); idle(); idle();
        // Aliasing on index 4.
        upd(32'h10, 1, 32'h40); upd(32'h10, 1, 32'h40);
        redir(32'h50); idle();
        upd(32'h50, 1, 32'h80);
        redir(32'h10); idle();
        redir(32'h50); idle(); idle();
        // Flush wins over a same-cycle allocate.
        cycle(0, 0, 1, 32'h50, 1, 32'h20, 1, 32'h60, 1);
        idle();
        redir(32'h20); idle();
        redir(32'h50); idle();
        // Wrap at the top of the address space.
        redir(32'hFFFF_FFFC); idle(); idle();
        // Reset mid-operation with an update in flight.
        upd(32'h30, 1, 32'h90);
        cycle(1, 0, 0, 0, 1, 32'h30, 1, 32'h90, 0);
        idle();
        redir(32'h30); idle();

        // Randomised traffic over a small address pool so hits and aliases occur.
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 99) < 10), rand_addr(),
                  ($urandom_range(0, 99) < 40), rand_addr(),
                  ($urandom_range(0, 99) < 60), rand_addr(),
                  ($urandom_range(0, 99) < 2));
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", q.size());
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the single-cycle PC register and next-PC mux, built for the pipelined core.
- Holds the fetch PC and supports stall and execute-stage redirect.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters so fetch can predict taken control flow.
- Sits at the front of the IF stage. PC drives instruction memory; pred_taken travels down the pipe to execute for mispredict detection.

Parameters:
WIDTH, 32, PC/address width in bits (>= 8)
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (4-byte aligned)
BTB_ENTRIES, 16, number of BTB entries; power of two, 2..256

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold PC (IF/ID back-pressure)
redirect  input  1  execute-stage mispredict/jump correction; flushes fetch path
redirect_pc  input  WIDTH  corrected next PC
upd_valid  input  1  a resolved branch/jump in execute updates the BTB this cycle
upd_pc  input  WIDTH  PC of the resolved instruction
upd_taken  input  1  resolved direction
upd_target  input  WIDTH  resolved target address
btb_flush  input  1  invalidate all BTB entries (fence.i)
PC  output  WIDTH  current fetch PC (registered)
pred_taken  output  1  BTB predicts current PC is taken (combinational from PC)
pc_plus4  output  WIDTH  PC + 4 (combinational)

Behaviour:
- Reset (async, immediate): PC = RESET_VECTOR; all BTB valid bits = 0; pred_taken = 0 as a consequence. Target, tag and counter contents are don't-care while invalid. Reset mid-operation aborts any in-flight update.
- Index/tag: IDX = log2(BTB_ENTRIES). Index = addr[IDX+1:2]; tag = addr[WIDTH-1:IDX+2]; addr[1:0] ignored.
- Entry fields: valid, tag, target[WIDTH-1:2], ctr[1:0].
- Lookup (combinational on PC):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - Predicted target = stored target with bits[1:0] = 00.
- Next-PC priority, registered at posedge:
  1. redirect: PC <= {redirect_pc[WIDTH-1:2], 2'b00}. Overrides stall.
  2. stall: PC holds.
  3. pred_taken: PC <= predicted target.
  4. otherwise: PC <= PC + 4.
- Arithmetic: PC + 4 wraps modulo 2^WIDTH, so all-ones-minus-3 goes to 0. No overflow flag.
- BTB update on upd_valid, posedge, independent of stall and redirect:
  - Hit on upd_pc, taken: ctr saturating increment (11 stays 11); target written with upd_target.
  - Hit on upd_pc, not taken: ctr saturating decrement (00 stays 00); target unchanged; entry stays valid.
  - Miss, taken: allocate/replace: valid = 1, tag, target, ctr = 10 (weakly taken).
  - Miss, not taken: no write.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents (no bypass). New contents are visible the cycle after the edge.
- btb_flush: all valid bits cleared at posedge. If asserted together with upd_valid, flush wins and no entry is written. PC behaviour that cycle is unaffected (lookup still uses old contents).
- No other state. Single clock domain; no multicycle paths.

Test Plan:
- Reset/sequential: rst=1 with RESET_VECTOR=0 -> PC=0, pred_taken=0. Release rst, 3 cycles -> PC=0x4, 0x8, 0xC; pc_plus4 tracks PC+4.
- Stall and redirect: at PC=0x8, stall=1 for 2 cycles -> PC stays 0x8, then 0xC after stall drops. Next, stall=1 and redirect=1 with redirect_pc=0x103 -> PC=0x100 next cycle.
- Allocate/predict: upd_valid, upd_pc=0x10, upd_taken=1, upd_target=0x40. When PC reaches 0x10 -> pred_taken=1 and PC=0x40 next cycle. Same cycle as the allocating edge, lookup of 0x10 still misses.
- Counter hysteresis: from allocated ctr=10, one taken update -> 11. One not-taken update -> 10, still pred_taken=1 at 0x10. Second not-taken update -> 01, pred_taken=0, fetch goes 0x10 -> 0x14. Further not-taken updates saturate at 00.
- Aliasing: BTB_ENTRIES=16, entry for 0x10 valid. PC=0x50 (same index 4) -> pred_taken=0 (tag mismatch). Taken update at 0x50 -> target 0x80 replaces; PC=0x10 then misses.
- Flush and wrap: btb_flush=1 together with upd_valid taken -> no entry valid afterwards. Redirect to 0xFFFF_FFFC, no prediction -> PC=0x0000_0000 next cycle.
